// File: rtl/clk_pixel_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_pixel_gen_pkg
// Description : Shared types and sizing helpers for the pixel-clock generator.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_pixel_gen_pkg;

  // Lock tracker: waits for the first pixel rising edge, then holds.
  typedef enum logic [0:0] {
    LOCK_WAIT = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // High-phase length: the extra cycle of an odd ratio goes to the low phase.
  function automatic int unsigned hi_len(input int unsigned div);
    return div / 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage : clk_pixel_gen_pkg
`default_nettype wire

// File: rtl/clk_pixel_gen_phase.sv
`default_nettype none
// ============================================================================
// Module      : clk_pixel_gen_phase
// Description : Modulo-DIV phase counter; exposes the next-state phase value.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_pixel_gen_phase
  import clk_pixel_gen_pkg::*;
#(
  parameter int unsigned DIV   = 2,
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_next_o
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == c_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;

endmodule : clk_pixel_gen_phase
`default_nettype wire

// File: rtl/clk_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_pixel_gen
// Description : Registered divide-by-DIV pixel clock with enable strobe and lock.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_pixel_gen
  import clk_pixel_gen_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic clk_pixel,
  output logic pix_en,
  output logic locked
);

  localparam int unsigned HI    = hi_len(DIV);
  localparam int unsigned CNT_W = cnt_width(DIV);

  // Phase value at which clk_pixel goes high; the low phase precedes it.
  localparam logic [CNT_W-1:0] c_rise = CNT_W'(DIV - HI);

  logic [CNT_W-1:0] w_cnt_next;
  logic             w_high;
  logic             w_rise;

  logic             clk_pixel_q;
  logic             pix_en_q;
  lock_state_e      lock_q;
  lock_state_e      lock_d;

  clk_pixel_gen_phase #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .cnt_next_o (w_cnt_next)
  );

  // Decoding the next phase lets every output come straight from a flop.
  assign w_high = (w_cnt_next >= c_rise);
  assign w_rise = (w_cnt_next == c_rise);

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      LOCK_WAIT: if (w_rise) lock_d = LOCK_HELD;
      LOCK_HELD: lock_d = LOCK_HELD;
      default:   lock_d = LOCK_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_pixel_q <= 1'b0;
      pix_en_q    <= 1'b0;
      lock_q      <= LOCK_WAIT;
    end else begin
      clk_pixel_q <= w_high;
      pix_en_q    <= w_rise;
      lock_q      <= lock_d;
    end
  end

  assign clk_pixel = clk_pixel_q;
  assign pix_en    = pix_en_q;
  assign locked    = (lock_q == LOCK_HELD);

endmodule : clk_pixel_gen
`default_nettype wire

// File: tb/tb_clk_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_pixel_gen
// Description : Scoreboard bench for clk_pixel_gen at DIV = 2, 3 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_pixel_gen;

  logic clk;
  logic rst;
  logic cp2, pe2, lk2;
  logic cp3, pe3, lk3;
  logic cp4, pe4, lk4;

  int n_checks = 0;
  int n_errors = 0;
  int k        = 0;

  typedef struct packed {
    logic [2:0] d2;
    logic [2:0] d3;
    logic [2:0] d4;
  } exp_t;

  exp_t q[$];

  clk_pixel_gen #(.DIV(2)) u_dut2 (.clk(clk), .rst(rst), .clk_pixel(cp2), .pix_en(pe2), .locked(lk2));
  clk_pixel_gen #(.DIV(3)) u_dut3 (.clk(clk), .rst(rst), .clk_pixel(cp3), .pix_en(pe3), .locked(lk3));
  clk_pixel_gen #(.DIV(4)) u_dut4 (.clk(clk), .rst(rst), .clk_pixel(cp4), .pix_en(pe4), .locked(lk4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Waveform model in terms of edges k since release: low DIV-HI, high HI.
  function automatic logic [2:0] mdl(input int div, input int kk);
    int ph;
    int rise;
    ph   = kk % div;
    rise = div - div / 2;
    return {(kk >= rise), (ph == rise), (ph >= rise)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
    end else begin
      k = k + 1;
      q.push_back('{d2: mdl(2, k), d3: mdl(3, k), d4: mdl(4, k)});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("d2_outs", {29'd0, lk2, pe2, cp2}, {29'd0, e.d2});
      chk("d3_outs", {29'd0, lk3, pe3, cp3}, {29'd0, e.d3});
      chk("d4_outs", {29'd0, lk4, pe4, cp4}, {29'd0, e.d4});
    end
  end

  initial begin
    logic [6:0] pat_cp;
    logic [6:0] pat_pe;
    int cnt_pe2, cnt_hi2, cnt_pe3, cnt_pe4;
    pat_cp = 7'b0110011;
    pat_pe = 7'b0100010;
    rst = 1'b1;

    // Long reset with a running clock: everything stays low.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold", {23'd0, cp2, pe2, lk2, cp3, pe3, lk3, cp4, pe4, lk4}, 32'd0);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Park DIV=4 in its high phase, then hit reset between edges.
    for (int n = 0; n < 8 && (k % 4) != 2; n++) @(negedge clk);
    #1;
    chk("pre_rst_cp4", {31'd0, cp4}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst", {23'd0, cp2, pe2, lk2, cp3, pe3, lk3, cp4, pe4, lk4}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // Literal DIV=4 sequence after release.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("d4_seq_cp", {31'd0, cp4}, {31'd0, pat_cp[6-i]});
      chk("d4_seq_pe", {31'd0, pe4}, {31'd0, pat_pe[6-i]});
    end

    // Long run from a fresh release: pulse counts and duty.
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    cnt_pe2 = 0; cnt_hi2 = 0; cnt_pe3 = 0; cnt_pe4 = 0;
    for (int i = 0; i < 16000; i++) begin
      @(posedge clk);
      #1;
      cnt_pe2 += int'(pe2);
      cnt_hi2 += int'(cp2);
      cnt_pe3 += int'(pe3);
      cnt_pe4 += int'(pe4);
    end
    chk("d2_pulses", cnt_pe2, 32'd8000);
    chk("d2_high",   cnt_hi2, 32'd8000);
    chk("d3_pulses", cnt_pe3, 32'd5333);
    chk("d4_pulses", cnt_pe4, 32'd4000);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_clk_pixel_gen
`default_nettype wire
